// File: rtl/pdc_pkg.sv
// pdc_pkg: shared constants for param_display_counter
// Holds the active-low a..g segment glyphs (MSB = a), the BCD digit maximum and the segment width.
package pdc_pkg;
  localparam int SEG_W = 7;
  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
  localparam logic [15:0][SEG_W-1:0] SEG_GLYPH = {
    7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08, 7'h04, 7'h00,
    7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01
  };
endpackage

// File: rtl/hex7seg_dec.sv
// hex7seg_dec: 4-bit value to active-low 7-segment glyph (0-9, A, b, C, d, E, F)
// Ports: i_val - digit value; o_seg - segments a..g, MSB = a, active-low.
module hex7seg_dec
  import pdc_pkg::*;
(
  input  logic [3:0]       i_val,
  output logic [SEG_W-1:0] o_seg
);
  assign o_seg = SEG_GLYPH[i_val];
endmodule

// File: rtl/param_display_counter.sv
// param_display_counter: push-button stepped hex/BCD up/down counter driving DIGITS 7-segment displays
// Ports: clock, resetn (async active-low); step_n raw button (pressed = 0); cnt_en, sclr, up, load, load_val controls;
// q count (digit 0 in q[3:0]); tick accepted press pulse; tc terminal count; hex active-low segments per digit.
// Optional: PDC_DEBOUNCE_EN adds a DEB_CYCLES stable-sample filter before the edge detector.
module param_display_counter
  import pdc_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int BCD        = 0,
  parameter int SATURATE   = 0,
  parameter int DEB_CYCLES = 16
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      step_n,
  input  logic                      cnt_en,
  input  logic                      sclr,
  input  logic                      up,
  input  logic                      load,
  input  logic [4*DIGITS-1:0]       load_val,
  output logic [4*DIGITS-1:0]       q,
  output logic                      tick,
  output logic                      tc,
  output logic [SEG_W*DIGITS-1:0]   hex
);
  localparam int W = 4 * DIGITS;
  if (DIGITS < 1 || DIGITS > 8 || DEB_CYCLES < 1) begin : g_bad_param
    $error("param_display_counter: DIGITS must be 1..8 and DEB_CYCLES >= 1");
  end
  logic         r_s1, r_s2, r_prev, r_arm;
  logic [1:0]   r_vld;
  logic         w_lvl, w_fall, w_step, w_c;
  logic [3:0]   w_d;
  logic [W-1:0] w_max, w_load, w_bcd, w_next;
`ifdef PDC_DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CYCLES + 1);
  logic          r_flt;
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      r_flt <= 1'b1;
      r_cnt <= '0;
    end else if (r_s2 == r_flt) r_cnt <= '0;
    else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
      r_flt <= r_s2;
      r_cnt <= '0;
    end else r_cnt <= r_cnt + 1'b1;
  assign w_lvl = r_flt;
`else
  assign w_lvl = r_s2;
`endif
  // r_arm stays low after reset until the synchronised button is seen released,
  // so a button held through reset cannot produce a tick.
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      r_s1   <= 1'b1;
      r_s2   <= 1'b1;
      r_prev <= 1'b1;
      r_vld  <= 2'b00;
      r_arm  <= 1'b0;
      tick   <= 1'b0;
    end else begin
      r_s1   <= step_n;
      r_s2   <= r_s1;
      r_prev <= w_lvl;
      r_vld  <= {r_vld[0], 1'b1};
      r_arm  <= r_arm | (r_vld[1] & r_s2);
      tick   <= w_fall;
    end
  assign w_fall = r_arm & r_prev & ~w_lvl;
  // Decimal cascade: w_c is the carry/borrow rippling from digit 0 upward.
  always_comb begin
    w_max  = '0;
    w_load = load_val;
    w_bcd  = q;
    w_c    = 1'b1;
    w_d    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      w_d = q[4*i+:4];
      w_max[4*i+:4]  = BCD != 0 ? BCD_MAX_DIGIT : 4'hF;
      w_load[4*i+:4] = (BCD != 0 && load_val[4*i+:4] > BCD_MAX_DIGIT) ? BCD_MAX_DIGIT : load_val[4*i+:4];
      w_bcd[4*i+:4]  = !w_c ? w_d :
                       up ? (w_d == BCD_MAX_DIGIT ? 4'd0 : w_d + 4'd1) :
                            (w_d == 4'd0 ? BCD_MAX_DIGIT : w_d - 4'd1);
      w_c = w_c & (up ? w_d == BCD_MAX_DIGIT : w_d == 4'd0);
    end
  end
  assign w_next = BCD != 0 ? w_bcd : (up ? q + W'(1) : q - W'(1));
  assign tc     = cnt_en & (up ? q == w_max : q == '0);
  assign w_step = w_fall & cnt_en & (SATURATE == 0 || !tc);
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) q <= '0;
    else if (sclr) q <= '0;
    else if (load) q <= w_load;
    else if (w_step) q <= w_next;
  for (genvar d = 0; d < DIGITS; d++) begin : g_dig
    hex7seg_dec u_dec (.i_val(q[4*d+:4]), .o_seg(hex[SEG_W*d+:SEG_W]));
  end
endmodule

// File: tb/tb_param_display_counter.sv
// tb_param_display_counter: directed self-checking bench for param_display_counter (binary, BCD and saturating builds)
module tb_param_display_counter;
`ifdef PDC_DEBOUNCE_EN
  localparam int LAT = 19;
`else
  localparam int LAT = 3;
`endif
  logic clock = 0, resetn = 0, step_n = 1, cnt_en = 1, sclr = 0, up = 1, load = 0;
  logic [15:0] load_val = '0;
  logic [15:0] q_b, q_d, q_s;
  logic tick_b, tick_d, tick_s, tc_b, tc_d, tc_s;
  logic [27:0] hex_b, hex_d, hex_s;
  logic [27:0] zero_hex = {4{7'h01}};
  int checks = 0, errors = 0, n_ticks = 0, first = 0;
  always #5 clock = ~clock;
  param_display_counter #(.DIGITS(4), .BCD(0), .SATURATE(0), .DEB_CYCLES(16)) dut_b (
    .clock(clock), .resetn(resetn), .step_n(step_n), .cnt_en(cnt_en), .sclr(sclr), .up(up),
    .load(load), .load_val(load_val), .q(q_b), .tick(tick_b), .tc(tc_b), .hex(hex_b));
  param_display_counter #(.DIGITS(4), .BCD(1), .SATURATE(0), .DEB_CYCLES(16)) dut_d (
    .clock(clock), .resetn(resetn), .step_n(step_n), .cnt_en(cnt_en), .sclr(sclr), .up(up),
    .load(load), .load_val(load_val), .q(q_d), .tick(tick_d), .tc(tc_d), .hex(hex_d));
  param_display_counter #(.DIGITS(4), .BCD(0), .SATURATE(1), .DEB_CYCLES(16)) dut_s (
    .clock(clock), .resetn(resetn), .step_n(step_n), .cnt_en(cnt_en), .sclr(sclr), .up(up),
    .load(load), .load_val(load_val), .q(q_s), .tick(tick_s), .tc(tc_s), .hex(hex_s));
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
      if (tick_b) n_ticks++;
    end
  endtask
  task automatic press(input int hold);
    first  = 0;
    step_n = 0;
    for (int i = 1; i <= hold; i++) begin
      cyc(1);
      if (tick_b && first == 0) first = i;
    end
    step_n = 1;
    cyc(LAT + 4);
  endtask
  task automatic test_reset;
    cyc(2);
    checks++; if (q_b !== 16'h0000) begin errors++; $display("FAIL reset_q got %h exp 0000", q_b); end
    checks++; if (tick_b !== 1'b0) begin errors++; $display("FAIL reset_tick got %b exp 0", tick_b); end
    checks++; if (hex_b !== zero_hex) begin errors++; $display("FAIL reset_hex got %h exp %h", hex_b, zero_hex); end
    checks++; if (tc_b !== 1'b0) begin errors++; $display("FAIL reset_tc_up got %b exp 0", tc_b); end
    up = 0; #1;
    checks++; if (tc_b !== 1'b1) begin errors++; $display("FAIL reset_tc_down got %b exp 1", tc_b); end
    up = 1;
    resetn = 1;
    cyc(5);
  endtask
  task automatic test_single_step;
    int t = n_ticks;
    press(LAT + 7);
    checks++; if (n_ticks - t !== 1) begin errors++; $display("FAIL step_ticks got %0d exp 1", n_ticks - t); end
    checks++; if (first !== LAT) begin errors++; $display("FAIL step_latency got %0d exp %0d", first, LAT); end
    checks++; if (q_b !== 16'h0001) begin errors++; $display("FAIL step_q got %h exp 0001", q_b); end
    checks++; if (hex_b[6:0] !== 7'b1001111) begin errors++; $display("FAIL step_hex got %b exp 1001111", hex_b[6:0]); end
    checks++; if (q_d !== 16'h0001) begin errors++; $display("FAIL step_q_bcd got %h exp 0001", q_d); end
  endtask
  task automatic test_bcd_cascade;
    load_val = 16'h0999; load = 1; cyc(1); load = 0;
    checks++; if (q_d !== 16'h0999) begin errors++; $display("FAIL bcd_load got %h exp 0999", q_d); end
    press(LAT + 7);
    checks++; if (q_d !== 16'h1000) begin errors++; $display("FAIL bcd_up got %h exp 1000", q_d); end
    checks++; if (q_b !== 16'h099A) begin errors++; $display("FAIL bin_up got %h exp 099a", q_b); end
    checks++; if (hex_d[27:21] !== 7'h4F || hex_d[13:7] !== 7'h01) begin errors++; $display("FAIL bcd_hex got %h exp digit3 4f digit1 01", hex_d); end
    up = 0;
    press(LAT + 7);
    checks++; if (q_d !== 16'h0999) begin errors++; $display("FAIL bcd_down got %h exp 0999", q_d); end
    up = 1;
  endtask
  task automatic test_terminal;
    load_val = 16'hFFFF; load = 1; cyc(1); load = 0;
    checks++; if (q_d !== 16'h9999) begin errors++; $display("FAIL bcd_clamp_all got %h exp 9999", q_d); end
    checks++; if (tc_b !== 1'b1 || tc_d !== 1'b1 || tc_s !== 1'b1) begin errors++; $display("FAIL tc_max got %b%b%b exp 111", tc_b, tc_d, tc_s); end
    checks++; if (hex_s[6:0] !== 7'h38) begin errors++; $display("FAIL hex_f got %h exp 38", hex_s[6:0]); end
    press(LAT + 7);
    checks++; if (q_b !== 16'h0000) begin errors++; $display("FAIL wrap_up got %h exp 0000", q_b); end
    checks++; if (q_s !== 16'hFFFF) begin errors++; $display("FAIL sat_up got %h exp ffff", q_s); end
    checks++; if (q_d !== 16'h0000) begin errors++; $display("FAIL bcd_wrap_up got %h exp 0000", q_d); end
    up = 0; #1;
    checks++; if (tc_b !== 1'b1) begin errors++; $display("FAIL tc_zero got %b exp 1", tc_b); end
    press(LAT + 7);
    checks++; if (q_b !== 16'hFFFF) begin errors++; $display("FAIL wrap_down got %h exp ffff", q_b); end
    checks++; if (q_d !== 16'h9999) begin errors++; $display("FAIL bcd_wrap_down got %h exp 9999", q_d); end
    checks++; if (q_s !== 16'hFFFE) begin errors++; $display("FAIL sat_down got %h exp fffe", q_s); end
    cnt_en = 0; #1;
    checks++; if (tc_s !== 1'b0) begin errors++; $display("FAIL tc_disabled got %b exp 0", tc_s); end
    cnt_en = 1; up = 1;
  endtask
  task automatic test_priority;
    step_n = 0;
    cyc(LAT - 1);
    sclr = 1; load = 1; load_val = 16'h1234;
    cyc(1);
    checks++; if (tick_b !== 1'b1 || tick_d !== 1'b1 || tick_s !== 1'b1) begin errors++; $display("FAIL prio_tick got %b%b%b exp 111", tick_b, tick_d, tick_s); end
    checks++; if (q_b !== 16'h0000 || q_d !== 16'h0000) begin errors++; $display("FAIL prio_sclr got %h %h exp 0000", q_b, q_d); end
    sclr = 0;
    cyc(1);
    checks++; if (q_b !== 16'h1234) begin errors++; $display("FAIL prio_load got %h exp 1234", q_b); end
    load_val = 16'h00AF;
    cyc(1);
    load = 0;
    checks++; if (q_d !== 16'h0099) begin errors++; $display("FAIL bcd_clamp got %h exp 0099", q_d); end
    checks++; if (q_b !== 16'h00AF) begin errors++; $display("FAIL bin_load got %h exp 00af", q_b); end
    step_n = 1;
    cyc(LAT + 4);
  endtask
  task automatic test_cnt_en;
    int t = n_ticks;
    cnt_en = 0;
    press(LAT + 7);
    checks++; if (q_b !== 16'h00AF) begin errors++; $display("FAIL cnt_en_hold got %h exp 00af", q_b); end
    checks++; if (n_ticks - t !== 1) begin errors++; $display("FAIL cnt_en_tick got %0d exp 1", n_ticks - t); end
    cnt_en = 1;
  endtask
  task automatic test_held;
    int t = n_ticks;
    press(100);
    checks++; if (n_ticks - t !== 1) begin errors++; $display("FAIL held_ticks got %0d exp 1", n_ticks - t); end
    checks++; if (q_b !== 16'h00B0) begin errors++; $display("FAIL held_q got %h exp 00b0", q_b); end
  endtask
  task automatic test_reset_mid_press;
    int t;
    step_n = 0;
    cyc(LAT + 5);
    checks++; if (q_b !== 16'h00B1) begin errors++; $display("FAIL mid_pre got %h exp 00b1", q_b); end
    resetn = 0; #1;
    checks++; if (q_b !== 16'h0000 || q_d !== 16'h0000 || tick_b !== 1'b0) begin errors++; $display("FAIL mid_reset got %h %h %b exp 0000 0000 0", q_b, q_d, tick_b); end
    cyc(2);
    resetn = 1;
    t = n_ticks;
    cyc(40);
    checks++; if (n_ticks - t !== 0 || q_b !== 16'h0000) begin errors++; $display("FAIL mid_held got ticks %0d q %h exp 0 0000", n_ticks - t, q_b); end
    step_n = 1;
    cyc(LAT + 4);
    press(LAT + 7);
    checks++; if (q_b !== 16'h0001) begin errors++; $display("FAIL mid_repress got %h exp 0001", q_b); end
  endtask
`ifdef PDC_DEBOUNCE_EN
  task automatic test_debounce;
    int t = n_ticks;
    step_n = 0;
    cyc(5);
    step_n = 1;
    cyc(40);
    checks++; if (n_ticks - t !== 0 || q_b !== 16'h0001) begin errors++; $display("FAIL glitch got ticks %0d q %h exp 0 0001", n_ticks - t, q_b); end
    t = n_ticks;
    press(40);
    checks++; if (n_ticks - t !== 1) begin errors++; $display("FAIL deb_ticks got %0d exp 1", n_ticks - t); end
    checks++; if (first !== 19) begin errors++; $display("FAIL deb_latency got %0d exp 19", first); end
    checks++; if (q_b !== 16'h0002) begin errors++; $display("FAIL deb_q got %h exp 0002", q_b); end
  endtask
`endif
  initial begin
    test_reset;
    test_single_step;
    test_bcd_cascade;
    test_terminal;
    test_priority;
    test_cnt_en;
    test_held;
    test_reset_mid_press;
`ifdef PDC_DEBOUNCE_EN
    test_debounce;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/param_display_counter.md
Name: param_display_counter

Overview:
- Parametrised successor to the 16-bit push-button counter: DIGITS-digit counter, hex or BCD radix, up/down, parallel load, wrap or saturate.
- Drives one 7-segment display per digit.
- Sits between board I/O (KEY/SW) and the HEX displays.
- Counting is advanced by a synchronised, edge-detected push-button tick on the system clock, not by using the key as a clock.

Parameters:
- DIGITS, 4, number of 4-bit digits and displays (1..8).
- BCD, 0, 0 = each digit 0..F binary-weighted whole word; 1 = each digit 0..9 decimal cascade.
- SATURATE, 0, 0 = wrap at terminal value; 1 = hold at terminal value.
- DEB_CYCLES, 16, stable-sample count for the debouncer (used only with PDC_DEBOUNCE_EN).

Ports:
- clock  input  1  system clock, rising edge.
- resetn  input  1  asynchronous, active-low reset.
- step_n  input  1  raw push-button level, active-low (pressed = 0), asynchronous to clock.
- cnt_en  input  1  count enable.
- sclr  input  1  synchronous clear.
- up  input  1  1 = count up, 0 = count down.
- load  input  1  synchronous parallel load.
- load_val  input  4*DIGITS  value to load.
- q  output  4*DIGITS  current count, digit 0 in q[3:0].
- tick  output  1  registered single-cycle pulse marking an accepted button press.
- tc  output  1  terminal count.
- hex  output  7*DIGITS  segment bus, active-low; per digit bits ordered a..g, MSB = a.

Behaviour:
- Reset (resetn = 0, asynchronous):
  - q = 0, tick = 0.
  - Synchroniser flops = 1 (released button).
  - Edge-detect state = 1.
  - hex shows all '0'.
- Input path: step_n → 2-flop synchroniser → falling-edge detect.
  - tick = 1 for exactly one clock, 3 clocks after step_n falls.
  - Holding the button produces one tick only.
- q update on each rising clock, priority order:
  - sclr = 1: q = 0, regardless of tick or cnt_en.
  - else load = 1: q = load_val. In BCD mode, any digit > 9 in load_val is stored as 9.
  - else tick & cnt_en: q steps ±1 per up.
  - else q holds.
- BCD = 0: q is a plain 4*DIGITS-bit binary value; max = all ones.
- BCD = 1 counting:
  - Up: a digit at 9 rolls to 0 and carries into the next digit.
  - Down: a digit at 0 rolls to 9 and borrows from the next digit.
  - max = all digits 9.
- Terminal count: tc = cnt_en & ((up & q == max) | (~up & q == 0)). tc is combinational from registers and inputs.
- At terminal count, when a counting step occurs:
  - SATURATE = 0: q wraps (max → 0 counting up, 0 → max counting down).
  - SATURATE = 1: q holds.
- up changing in the same cycle as a tick: the new value of up applies.
- Segment outputs: hex is combinational from q, one decoder per digit, glyphs 0-9, A, b, C, d, E, F.
- resetn asserted mid-press: state is cleared immediately. A button still held at release generates no tick until it is released and pressed again.
- Latency: press to q change = 3 clocks; press to hex change = 3 clocks (plus decoder delay).

Optional Feature:
- Macro PDC_DEBOUNCE_EN.
- When defined:
  - A counter between the synchroniser and the edge detector requires DEB_CYCLES consecutive identical samples before the filtered level changes.
  - Press-to-tick latency becomes 3 + DEB_CYCLES clocks.
  - Glitches shorter than DEB_CYCLES produce no tick.
  - Reset sets the filtered level to 1 and clears the counter.
- When undefined: no filter; 3-clock latency; DEB_CYCLES is ignored.

Decomposition:
- Shared package pdc_pkg holds:
  - the 7-segment glyph constants (16 entries, active-low, a..g);
  - the BCD_MAX_DIGIT = 4'd9 constant;
  - the segment-width constant SEG_W = 7.
- One sub-module, hex7seg_dec: 4-bit in, 7-bit out, combinational. It is instantiated DIGITS times via generate.

Test Plan:
- Reset and single step, DIGITS = 4, BCD = 0, cnt_en = 1, up = 1:
  - Release resetn, press step_n for 10 clocks → one tick, q = 16'h0001.
  - hex[6:0] = 7'b1001111 (glyph '1').
- BCD cascade, BCD = 1: load_val = 16'h0999, load pulse, then one press up → q = 16'h1000.
  - Then one press down → q = 16'h0999.
- Wrap and saturate at terminal count:
  - SATURATE = 0, BCD = 0, q = 16'hFFFF, up = 1 → tc = 1; after a press q = 16'h0000.
  - SATURATE = 1, same stimulus → q stays 16'hFFFF.
- Priority: sclr = 1, load = 1, load_val = 16'h1234, and a tick all in the same cycle → q = 0.
  - Next cycle, load = 1 only → q = 16'h1234.
  - BCD = 1, load_val = 16'h00AF → q = 16'h0099.
- Held button and mid-press reset:
  - Hold step_n low for 100 clocks → exactly one increment.
  - Pulse resetn low while the button is held → q = 0; no tick until release and re-press.
- PDC_DEBOUNCE_EN defined, DEB_CYCLES = 16:
  - 5-clock glitch on step_n → no tick.
  - 40-clock press → exactly one tick, 19 clocks after the falling edge.
